sdram_port_scheduler: RTL and testbench

SDRAM_PORT_SCHEDULER -- requirements
Module: sdram_port_scheduler

---
 rtl/sdram_port_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_sdram_port_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_scheduler.sv
// Burst scheduler arbitrating one TV write FIFO and two field read FIFOs onto an SDRAM command engine.
// Optional watchdog on the WAIT state is enabled by defining SCHED_WATCHDOG_EN.
module sdram_port_scheduler #(
  parameter int unsigned LENGTH   = 128,
  parameter int unsigned WR1_BASE = 0,
  parameter int unsigned WR1_MAX  = 324480,
  parameter int unsigned RD1_BASE = 8320,
  parameter int unsigned RD1_MAX  = 161920,
  parameter int unsigned RD2_BASE = 170880,
  parameter int unsigned RD2_MAX  = 324480,
  parameter int unsigned WD_LIMIT = 1023
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [8:0]  iWR1_USEDW,
  input  logic [8:0]  iRD1_USEDW,
  input  logic [8:0]  iRD2_USEDW,
  input  logic        iWR1_LOAD,
  input  logic        iRD1_LOAD,
  input  logic        iRD2_LOAD,
  input  logic        iDONE,
  output logic        oREQ,
  output logic [1:0]  oMODE,
  output logic [21:0] oADDR,
  output logic [8:0]  oLEN,
  output logic        oBUSY,
  output logic        oERR
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_WAIT = 2'd2} state_t;

  localparam logic [1:0]  M_NONE = 2'b00;
  localparam logic [1:0]  M_WR1  = 2'b01;
  localparam logic [1:0]  M_RD1  = 2'b10;
  localparam logic [1:0]  M_RD2  = 2'b11;
  localparam logic [8:0]  LEN_W  = LENGTH[8:0];
  localparam logic [21:0] LEN_A  = LENGTH[21:0];
  localparam logic [21:0] WR1_B  = WR1_BASE[21:0];
  localparam logic [21:0] WR1_M  = WR1_MAX[21:0];
  localparam logic [21:0] RD1_B  = RD1_BASE[21:0];
  localparam logic [21:0] RD1_M  = RD1_MAX[21:0];
  localparam logic [21:0] RD2_B  = RD2_BASE[21:0];
  localparam logic [21:0] RD2_M  = RD2_MAX[21:0];

  // Sum is formed one bit wider so the wrap test never sees a truncated value.
  function automatic logic [21:0] advance(input logic [21:0] ptr, input logic [21:0] base,
                                          input logic [21:0] max);
    logic [22:0] sum;
    sum = {1'b0, ptr} + {1'b0, LEN_A};
    if (sum >= {1'b0, max}) begin
      return base;
    end else begin
      return sum[21:0];
    end
  endfunction

  state_t      state_q;
  logic        req_q, busy_q, rr_rd2_q;
  logic [1:0]  mode_q, grant_d;
  logic [21:0] addr_q, grant_addr_d;
  logic [21:0] wr1_ptr_q, rd1_ptr_q, rd2_ptr_q;
  logic [21:0] wr1_ptr_d, rd1_ptr_d, rd2_ptr_d;
  logic        wr1_elig_s, rd1_elig_s, rd2_elig_s, adv_s;

  assign wr1_elig_s = (iWR1_USEDW >= LEN_W);
  assign rd1_elig_s = (iRD1_USEDW < LEN_W);
  assign rd2_elig_s = (iRD2_USEDW < LEN_W);
  assign adv_s      = (state_q == ST_WAIT) && iDONE;

  always_comb begin
    grant_d = M_NONE;
    if (wr1_elig_s) begin
      grant_d = M_WR1;
    end else if (rd1_elig_s && rd2_elig_s) begin
      grant_d = rr_rd2_q ? M_RD2 : M_RD1;
    end else if (rd1_elig_s) begin
      grant_d = M_RD1;
    end else if (rd2_elig_s) begin
      grant_d = M_RD2;
    end else begin
      grant_d = M_NONE;
    end
    case (grant_d)
      M_WR1:   grant_addr_d = wr1_ptr_q;
      M_RD1:   grant_addr_d = rd1_ptr_q;
      M_RD2:   grant_addr_d = rd2_ptr_q;
      default: grant_addr_d = 22'd0;
    endcase
  end

  // A reload beats a same-cycle burst completion on the same port.
  always_comb begin
    wr1_ptr_d = wr1_ptr_q;
    rd1_ptr_d = rd1_ptr_q;
    rd2_ptr_d = rd2_ptr_q;
    if (iWR1_LOAD) wr1_ptr_d = WR1_B;
    else if (adv_s && mode_q == M_WR1) wr1_ptr_d = advance(wr1_ptr_q, WR1_B, WR1_M);
    else wr1_ptr_d = wr1_ptr_q;
    if (iRD1_LOAD) rd1_ptr_d = RD1_B;
    else if (adv_s && mode_q == M_RD1) rd1_ptr_d = advance(rd1_ptr_q, RD1_B, RD1_M);
    else rd1_ptr_d = rd1_ptr_q;
    if (iRD2_LOAD) rd2_ptr_d = RD2_B;
    else if (adv_s && mode_q == M_RD2) rd2_ptr_d = advance(rd2_ptr_q, RD2_B, RD2_M);
    else rd2_ptr_d = rd2_ptr_q;
  end

`ifdef SCHED_WATCHDOG_EN
  localparam int unsigned WD_W    = (WD_LIMIT > 2) ? $clog2(WD_LIMIT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LIMIT - 1);
  logic [WD_W-1:0] wd_q;
  logic            err_q;
  assign oERR = err_q;
`else
  assign oERR = 1'b0;
`endif

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q   <= ST_IDLE;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      mode_q    <= M_NONE;
      addr_q    <= 22'd0;
      rr_rd2_q  <= 1'b0;
      wr1_ptr_q <= WR1_B;
      rd1_ptr_q <= RD1_B;
      rd2_ptr_q <= RD2_B;
`ifdef SCHED_WATCHDOG_EN
      wd_q      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      wr1_ptr_q <= wr1_ptr_d;
      rd1_ptr_q <= rd1_ptr_d;
      rd2_ptr_q <= rd2_ptr_d;
      case (state_q)
        ST_IDLE: begin
          if (grant_d != M_NONE) begin
            state_q <= ST_ISSUE;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
            mode_q  <= grant_d;
            addr_q  <= grant_addr_d;
            if (grant_d == M_RD1) rr_rd2_q <= 1'b1;
            else if (grant_d == M_RD2) rr_rd2_q <= 1'b0;
            else rr_rd2_q <= rr_rd2_q;
          end else begin
            req_q <= 1'b0;
          end
        end
        ST_ISSUE: begin
          req_q   <= 1'b0;
          state_q <= ST_WAIT;
`ifdef SCHED_WATCHDOG_EN
          wd_q    <= '0;
`endif
        end
        ST_WAIT: begin
          if (iDONE) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            mode_q  <= M_NONE;
            addr_q  <= 22'd0;
`ifdef SCHED_WATCHDOG_EN
          end else if (wd_q == WD_LAST) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            mode_q  <= M_NONE;
            addr_q  <= 22'd0;
            err_q   <= 1'b1;
          end else begin
            wd_q <= wd_q + 1'b1;
`else
          end else begin
            state_q <= ST_WAIT;
`endif
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
          mode_q  <= M_NONE;
          addr_q  <= 22'd0;
        end
      endcase
    end
  end

  assign oREQ  = req_q;
  assign oMODE = mode_q;
  assign oADDR = addr_q;
  assign oBUSY = busy_q;
  assign oLEN  = LEN_W;

endmodule

// File: tb/tb_sdram_port_scheduler.sv
// Self-checking bench: vector table of grants, scoreboard on oREQ, and hand-written corner sequences.
module tb_sdram_port_scheduler;
  logic        iCLK = 1'b0;
  logic        iRST;
  logic [8:0]  iWR1_USEDW, iRD1_USEDW, iRD2_USEDW;
  logic        iWR1_LOAD, iRD1_LOAD, iRD2_LOAD, iDONE;
  logic        oREQ, oBUSY, oERR;
  logic [1:0]  oMODE;
  logic [21:0] oADDR;
  logic [8:0]  oLEN;

  localparam logic [1:0] WR1 = 2'b01, RD1 = 2'b10, RD2 = 2'b11;

  typedef struct {
    logic [8:0]  wr, rd1, rd2;
    logic [1:0]  mode;
    logic [21:0] addr;
  } vec_t;
  typedef struct {
    logic [1:0]  mode;
    logic [21:0] addr;
  } exp_t;

  vec_t vecs[10];
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  sdram_port_scheduler dut (
    .iCLK(iCLK), .iRST(iRST),
    .iWR1_USEDW(iWR1_USEDW), .iRD1_USEDW(iRD1_USEDW), .iRD2_USEDW(iRD2_USEDW),
    .iWR1_LOAD(iWR1_LOAD), .iRD1_LOAD(iRD1_LOAD), .iRD2_LOAD(iRD2_LOAD),
    .iDONE(iDONE), .oREQ(oREQ), .oMODE(oMODE), .oADDR(oADDR), .oLEN(oLEN),
    .oBUSY(oBUSY), .oERR(oERR)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every burst strobe must match the oldest expected grant.
  always @(negedge iCLK) begin
    if (iRST === 1'b0 && oREQ === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_req", sb_q.size(), 1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("req_mode", oMODE, e.mode);
        chk("req_addr", oADDR, e.addr);
        chk("req_len", oLEN, 128);
      end
    end
  end

  task automatic park();
    iWR1_USEDW = 9'd0;
    iRD1_USEDW = 9'd200;
    iRD2_USEDW = 9'd200;
  endtask

  task automatic do_reset();
    iRST = 1'b1;
    iDONE = 1'b0;
    {iWR1_LOAD, iRD1_LOAD, iRD2_LOAD} = 3'b000;
    park();
    repeat (2) @(negedge iCLK);
    chk("rst_req", oREQ, 0);
    chk("rst_mode", oMODE, 0);
    chk("rst_addr", oADDR, 0);
    chk("rst_busy", oBUSY, 0);
    chk("rst_err", oERR, 0);
    chk("rst_len", oLEN, 128);
    iRST = 1'b0;
  endtask

  // Drive FIFO levels, expect a strobe one cycle later, then sit in WAIT.
  task automatic start(input logic [8:0] wr, input logic [8:0] rd1, input logic [8:0] rd2,
                       input logic [1:0] mode, input logic [21:0] addr);
    int n;
    exp_t e;
    iWR1_USEDW = wr;
    iRD1_USEDW = rd1;
    iRD2_USEDW = rd2;
    e.mode = mode;
    e.addr = addr;
    sb_q.push_back(e);
    n = 0;
    do begin
      @(negedge iCLK);
      n++;
    end while (oREQ !== 1'b1 && n < 8);
    chk("req_latency", n, 1);
    park();
    if (oREQ !== 1'b1) begin
      sb_q.delete();
    end else begin
      @(negedge iCLK);
      chk("req_pulse", oREQ, 0);
      chk("wait_busy", oBUSY, 1);
      chk("wait_mode", oMODE, mode);
      chk("wait_addr", oADDR, addr);
    end
  endtask

  task automatic finish(input logic [2:0] done_ld);
    iDONE = 1'b1;
    {iWR1_LOAD, iRD1_LOAD, iRD2_LOAD} = done_ld;
    @(negedge iCLK);
    iDONE = 1'b0;
    {iWR1_LOAD, iRD1_LOAD, iRD2_LOAD} = 3'b000;
    chk("idle_busy", oBUSY, 0);
    chk("idle_mode", oMODE, 0);
    chk("idle_addr", oADDR, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [21:0] ptr;
    vecs[0] = '{9'd128, 9'd200, 9'd200, WR1, 22'd0};
    vecs[1] = '{9'd128, 9'd200, 9'd200, WR1, 22'd128};
    vecs[2] = '{9'd0,   9'd0,   9'd0,   RD1, 22'd8320};
    vecs[3] = '{9'd0,   9'd0,   9'd0,   RD2, 22'd170880};
    vecs[4] = '{9'd0,   9'd0,   9'd0,   RD1, 22'd8448};
    vecs[5] = '{9'd127, 9'd127, 9'd127, RD2, 22'd171008};
    vecs[6] = '{9'd200, 9'd0,   9'd0,   WR1, 22'd256};
    vecs[7] = '{9'd0,   9'd128, 9'd0,   RD2, 22'd171136};
    vecs[8] = '{9'd0,   9'd0,   9'd128, RD1, 22'd8576};
    vecs[9] = '{9'd0,   9'd0,   9'd0,   RD2, 22'd171264};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      start(vecs[i].wr, vecs[i].rd1, vecs[i].rd2, vecs[i].mode, vecs[i].addr);
      finish(3'b000);
    end

    // Nothing eligible, plus a stray iDONE in IDLE that must not move WR1.
    park();
    for (int i = 0; i < 4; i++) begin
      @(negedge iCLK);
      chk("noelig_req", oREQ, 0);
      chk("noelig_busy", oBUSY, 0);
      chk("noelig_mode", oMODE, 0);
    end
    iDONE = 1'b1;
    @(negedge iCLK);
    iDONE = 1'b0;
    start(9'd128, 9'd200, 9'd200, WR1, 22'd384);
    finish(3'b000);
    // WR1 reload coinciding with an RD1 completion.
    start(9'd0, 9'd0, 9'd200, RD1, 22'd8704);
    finish(3'b100);
    start(9'd128, 9'd200, 9'd200, WR1, 22'd0);
    finish(3'b000);

    // Reset in the middle of WAIT; a later iDONE must be ignored.
    start(9'd128, 9'd200, 9'd200, WR1, 22'd128);
    iRST = 1'b1;
    @(negedge iCLK);
    iRST = 1'b0;
    chk("midrst_req", oREQ, 0);
    chk("midrst_mode", oMODE, 0);
    chk("midrst_addr", oADDR, 0);
    chk("midrst_busy", oBUSY, 0);
    iDONE = 1'b1;
    @(negedge iCLK);
    iDONE = 1'b0;
    chk("midrst_done_busy", oBUSY, 0);
    chk("midrst_done_req", oREQ, 0);
    start(9'd128, 9'd200, 9'd200, WR1, 22'd0);
    finish(3'b000);
    start(9'd0, 9'd0, 9'd0, RD1, 22'd8320);
    finish(3'b000);

    // RD2 reload and completion in the same cycle.
    do_reset();
    start(9'd0, 9'd200, 9'd0, RD2, 22'd170880);
    finish(3'b000);
    start(9'd0, 9'd200, 9'd0, RD2, 22'd171008);
    finish(3'b001);
    start(9'd0, 9'd200, 9'd0, RD2, 22'd170880);
    finish(3'b000);

    // RD1 reload mid-WAIT: burst continues, pointer restarts from base.
    do_reset();
    start(9'd0, 9'd0, 9'd200, RD1, 22'd8320);
    finish(3'b000);
    start(9'd0, 9'd0, 9'd200, RD1, 22'd8448);
    finish(3'b000);
    start(9'd0, 9'd0, 9'd200, RD1, 22'd8576);
    iRD1_LOAD = 1'b1;
    @(negedge iCLK);
    iRD1_LOAD = 1'b0;
    chk("midload_addr", oADDR, 22'd8576);
    chk("midload_busy", oBUSY, 1);
    chk("midload_mode", oMODE, RD1);
    finish(3'b000);
    start(9'd0, 9'd0, 9'd200, RD1, 22'd8448);
    finish(3'b000);

    // Long WAIT without iDONE.
    do_reset();
    start(9'd128, 9'd200, 9'd200, WR1, 22'd0);
`ifdef SCHED_WATCHDOG_EN
    repeat (1030) @(negedge iCLK);
    chk("wd_err", oERR, 1);
    chk("wd_busy", oBUSY, 0);
    chk("wd_mode", oMODE, 0);
    start(9'd128, 9'd200, 9'd200, WR1, 22'd0);
    finish(3'b000);
    chk("wd_err_sticky", oERR, 1);
`else
    repeat (1100) @(negedge iCLK);
    chk("nowd_busy", oBUSY, 1);
    chk("nowd_err", oERR, 0);
    chk("nowd_mode", oMODE, WR1);
    finish(3'b000);
    chk("nowd_err_after", oERR, 0);
`endif

    // RD1 walk through its whole region and wrap back to base.
    do_reset();
    ptr = 22'd8320;
    for (int k = 0; k <= 1200; k++) begin
      start(9'd0, 9'd0, 9'd200, RD1, ptr);
      finish(3'b000);
      ptr = ptr + 22'd128;
      if (ptr >= 22'd161920) ptr = 22'd8320;
    end

    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
